seg7_mmio_ctrl: RTL and testbench
=================================

Name: seg7_mmio_ctrl

Overview:
Memory-mapped display controller that sits directly upstream of the 8-digit seven-segment scan driver. It gives the CPU data bus a small register window (DATA/CTRL/STATUS) and selects either the CPU-written value or a live debug word. It produces the driver's one-cycle load strobe (o_cs) and 32-bit value (o_data). Updates are change-detected and rate-limited, so the display never receives redundant or flicker-rate loads.

Parameters:
BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; decode is bus_addr[31:4] == BASE_ADDR[31:4].
HOLD_CYCLES, 1024, minimum clk cycles between successive o_cs pulses; legal range 1..65535.

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
bus_we  in  1  write request, sampled each edge
bus_re  in  1  read request, sampled each edge
bus_addr  in  32  byte address
bus_wdata  in  32  write data
bus_be  in  4  byte enables; bit i covers wdata[8i+7:8i]
bus_rdata  out  32  read data, valid while bus_ready=1
bus_ready  out  1  one-cycle access acknowledge
dbg_data  in  32  live debug word (e.g. PC), synchronous to clk
o_cs  out  1  single-cycle load strobe to the display driver
o_data  out  32  value to display; stable except on o_cs cycles

Behaviour:
- Reset (reset=0, asynchronous): o_cs=0, o_data=0, bus_rdata=0, bus_ready=0. Internal DATA=0, CTRL=0, shadow=0, hold counter=0, commit count=0, state=IDLE. If reset asserts mid-WAIT, the pending update is discarded.
- Register map (offset = bus_addr[3:0]):
  - 0x0 DATA: RW; per-byte write under bus_be.
  - 0x4 CTRL: RW; bit0 SRC (0=DATA, 1=dbg_data), bit1 FREEZE; other bits read 0. bus_be[0] gates the write.
  - 0x8 STATUS: RO; bit0 = (state==WAIT); [31:16] = commit count, wrapping at 16 bits; others 0.
  - 0xC and unaligned offsets: read 0, writes ignored.
- Bus access, selected when address decodes and (bus_we|bus_re):
  - The register write takes effect at the sampling edge.
  - bus_ready=1 for exactly the following cycle.
  - bus_rdata is loaded at the same edge with the pre-write register contents; it returns 0 when not ready.
  - we and re together: the write occurs, and rdata returns the old value.
  - An unselected access gets no bus_ready and causes no state change.
  - Back-to-back accesses every cycle are supported.
- src_val = SRC ? dbg_data : DATA. diff = (src_val != shadow) & ~FREEZE.
- FSM (IDLE, WAIT), evaluated each edge:
  - IDLE: if diff and hold==0, commit. If diff and hold!=0, go to WAIT. Otherwise stay.
  - WAIT: if ~diff (value reverted or FREEZE set), go to IDLE with no pulse. If diff and hold==0, commit and go to IDLE.
  - Commit (at an edge): o_data<=src_val, shadow<=src_val, o_cs<=1, hold<=HOLD_CYCLES-1, commit count += 1.
  - o_cs<=0 at every non-commit edge.
- Hold counter: decrements by 1 each edge while nonzero, except at a commit edge, where it reloads.
  - Result: rising edges of o_cs are at least HOLD_CYCLES cycles apart.
  - HOLD_CYCLES=1 allows a commit every cycle.
- Latency: a DATA write sampled at edge E0 with hold==0 gives o_cs=1 and new o_data in the cycle after E1.
- The value committed is always the one current at the commit edge; intermediate values inside a hold window are dropped.
- After reset release with DATA=0 and SRC=0, no o_cs occurs until the source differs from 0.

Test Plan:
- Reset: hold reset=0 with random bus traffic -> all outputs 0. Release and idle 200 cycles -> o_cs never 1.
- Write DATA=0x1234ABCD, be=4'b1111 at E0 (HOLD=1024, idle) -> bus_ready=1 after E0. o_cs=1 for exactly one cycle after E1 with o_data=0x1234ABCD. Read DATA -> 0x1234ABCD. STATUS[31:16]=1.
- From DATA=0x1234ABCD, write 0xFFFFFFFF be=4'b0010 -> DATA=0x1234FFCD, committed to o_data. Write to offset 0xC -> ignored, reads 0.
- HOLD_CYCLES=16: write 0x11 at E0, 0x22 at E3, 0x33 at E5 -> o_cs pulses with o_data=0x11 after E1, then o_data=0x33 exactly 16 cycles later. 0x22 is never output. STATUS bit0=1 in between.
- HOLD_CYCLES=16: commit 0xAA, write 0xBB then 0xAA within 5 cycles -> no second pulse, FSM returns to IDLE, commit count unchanged.
- CTRL=0x3 (SRC=1, FREEZE=1) with dbg_data incrementing -> no o_cs. Write CTRL=0x1 -> o_cs within 1 cycle (hold expired) carrying the current dbg_data. Subsequent pulses exactly HOLD_CYCLES apart.

Source files
------------

// File: rtl/seg7_mmio_ctrl.sv
// seg7_mmio_ctrl: memory-mapped front end for the 8-digit seven-segment scan driver.
// Exposes a DATA/CTRL/STATUS register window on the CPU bus. It selects either the
// CPU-written value or a live debug word. Only changed values go to the driver, and
// loads are rate-limited to one per HOLD_CYCLES clocks.
// Ports:
//   clk, reset       - clock; asynchronous active-low reset
//   bus_we/bus_re    - write/read request, sampled each edge
//   bus_addr/wdata/be- byte address, write data, byte enables
//   bus_rdata/ready  - read data and one-cycle acknowledge (cycle after the access)
//   dbg_data         - live debug word, synchronous to clk
//   o_cs/o_data      - one-cycle load strobe and value for the display driver
module seg7_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_be,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic [31:0] dbg_data,
  output logic        o_cs,
  output logic [31:0] o_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] shadow_q;
  logic          src_q;
  logic          freeze_q;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] commit_cnt_q;

  logic          sel_c;
  logic          wr_c;
  logic [3:0]    offset_c;
  logic [DW-1:0] rd_mux_c;
  logic [DW-1:0] src_val_c;
  logic          diff_c;
  logic          hold_zero_c;
  logic          commit_c;

  // Address decode and pre-write read mux
  always_comb begin
    offset_c = bus_addr[3:0];
    sel_c    = (bus_addr[31:4] == BASE_ADDR[31:4]) && (bus_we || bus_re);
    wr_c     = sel_c && bus_we;
    rd_mux_c = '0;
    case (offset_c)
      OFF_DATA:   rd_mux_c = data_q;
      OFF_CTRL:   rd_mux_c = {30'b0, freeze_q, src_q};
      OFF_STATUS: rd_mux_c = {commit_cnt_q, 15'b0, (state_q == ST_WAIT)};
      default:    rd_mux_c = '0;
    endcase
  end

  // Change detection against the last committed value
  always_comb begin
    src_val_c   = src_q ? dbg_data : data_q;
    diff_c      = (src_val_c != shadow_q) && !freeze_q;
    hold_zero_c = (hold_q == '0);
  end

  // Update FSM: next state and commit decision
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (diff_c) begin
          if (hold_zero_c) commit_c = 1'b1;
          else             state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!diff_c) begin
          state_d = ST_IDLE;
        end else if (hold_zero_c) begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Bus-side registers: acknowledge, read data, DATA/CTRL writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      data_q    <= '0;
      src_q     <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      bus_ready <= sel_c;
      bus_rdata <= sel_c ? rd_mux_c : '0;
      if (wr_c && offset_c == OFF_DATA) begin
        for (int i = 0; i < 4; i++) begin
          if (bus_be[i]) data_q[8*i +: 8] <= bus_wdata[8*i +: 8];
        end
      end
      if (wr_c && offset_c == OFF_CTRL && bus_be[0]) begin
        src_q    <= bus_wdata[0];
        freeze_q <= bus_wdata[1];
      end
    end
  end

  // Display-side registers: commit, hold window, commit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cs         <= 1'b0;
      o_data       <= '0;
      shadow_q     <= '0;
      hold_q       <= '0;
      commit_cnt_q <= '0;
    end else begin
      o_cs <= commit_c;
      if (commit_c) begin
        o_data       <= src_val_c;
        shadow_q     <= src_val_c;
        hold_q       <= HOLD_RELOAD;
        commit_cnt_q <= commit_cnt_q + HW'(1);
      end else if (!hold_zero_c) begin
        hold_q <= hold_q - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_mmio_ctrl.sv
// Testbench for seg7_mmio_ctrl: two instances (HOLD_CYCLES=16 and 1) share one bus.
// Each instance is compared every cycle against a time-stamp based reference model.
// Explicit vectors cover the register map, latency, hold-window dropping, revert and freeze.
module tb_seg7_mmio_ctrl;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam int unsigned HOLD_A = 16;
  localparam int unsigned HOLD_B = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_we, bus_re;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] dbg_data;

  logic [31:0] rdata_a, odata_a, rdata_b, odata_b;
  logic        ready_a, cs_a, ready_b, cs_b;

  always #5 clk = ~clk;

  seg7_mmio_ctrl #(.BASE_ADDR(BASE), .HOLD_CYCLES(HOLD_A)) u_dut_a (
    .clk(clk), .reset(reset), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(rdata_a), .bus_ready(ready_a),
    .dbg_data(dbg_data), .o_cs(cs_a), .o_data(odata_a));

  seg7_mmio_ctrl #(.BASE_ADDR(BASE), .HOLD_CYCLES(HOLD_B)) u_dut_b (
    .clk(clk), .reset(reset), .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(rdata_b), .bus_ready(ready_b),
    .dbg_data(dbg_data), .o_cs(cs_b), .o_data(odata_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: commits are allowed when HOLD cycles have passed since the last one.
  typedef struct {
    logic [31:0] data;
    logic        src;
    logic        freeze;
    logic [31:0] shadow;
    logic        waiting;
    logic [15:0] cnt;
    longint      last;
    bit          any;
    logic        cs;
    logic [31:0] odata;
    logic        ready;
    logic [31:0] rdata;
  } model_t;

  model_t ma, mb;
  longint ncyc = 0;

  function automatic model_t model_reset();
    model_t m;
    m.data = '0; m.src = 1'b0; m.freeze = 1'b0; m.shadow = '0; m.waiting = 1'b0;
    m.cnt = '0; m.last = 0; m.any = 1'b0; m.cs = 1'b0; m.odata = '0;
    m.ready = 1'b0; m.rdata = '0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, longint n, int unsigned hold);
    model_t      r       = m;
    logic [31:0] src     = m.src ? dbg_data : m.data;
    bit          diff    = (src != m.shadow) && !m.freeze;
    bit          allowed = !m.any || ((n - m.last) >= longint'(hold));
    bit          sel     = (bus_addr[31:4] == BASE[31:4]) && (bus_we || bus_re);
    logic [31:0] rv;
    case (bus_addr[3:0])
      4'h0:    rv = m.data;
      4'h4:    rv = {30'b0, m.freeze, m.src};
      4'h8:    rv = {m.cnt, 15'b0, m.waiting};
      default: rv = '0;
    endcase
    r.ready = sel;
    r.rdata = sel ? rv : 32'h0;
    if (sel && bus_we && bus_addr[3:0] == 4'h0) begin
      for (int i = 0; i < 4; i++) if (bus_be[i]) r.data[8*i +: 8] = bus_wdata[8*i +: 8];
    end
    if (sel && bus_we && bus_addr[3:0] == 4'h4 && bus_be[0]) begin
      r.src    = bus_wdata[0];
      r.freeze = bus_wdata[1];
    end
    r.cs = diff && allowed;
    if (r.cs) begin
      r.odata  = src;
      r.shadow = src;
      r.cnt    = m.cnt + 16'd1;
      r.last   = n;
      r.any    = 1'b1;
    end
    r.waiting = diff && !allowed;
    return r;
  endfunction

  // Advance one clock, update models and compare both instances
  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset) begin
      ma = model_reset();
      mb = model_reset();
    end else begin
      ncyc++;
      ma = model_step(ma, ncyc, HOLD_A);
      mb = model_step(mb, ncyc, HOLD_B);
    end
    chk("cycle_h16", {cs_a, odata_a, ready_a, rdata_a}, {ma.cs, ma.odata, ma.ready, ma.rdata});
    chk("cycle_h1",  {cs_b, odata_b, ready_b, rdata_b}, {mb.cs, mb.odata, mb.ready, mb.rdata});
  endtask

  task automatic bus_set(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    bus_we = we; bus_re = re; bus_addr = addr; bus_wdata = wdata; bus_be = be;
  endtask

  task automatic bus_idle();
    bus_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic bus_random();
    logic [3:0] off;
    case ($urandom_range(0, 5))
      0, 1:    off = 4'h0;
      2:       off = 4'h4;
      3:       off = 4'h8;
      4:       off = 4'hC;
      default: off = 4'($urandom_range(0, 15));
    endcase
    bus_we    = ($urandom_range(0, 2) == 0);
    bus_re    = ($urandom_range(0, 2) == 0);
    bus_addr  = ($urandom_range(0, 7) == 0) ? $urandom : (BASE | {28'h0, off});
    bus_wdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    bus_be    = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) dbg_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    int          ncs;
    int          p1_k, p2_k;
    logic [31:0] p1_d, p2_d;
    logic [15:0] cnt1;
    logic [31:0] exp_dbg;

    vecs.push_back('{1'b0, 1'b1, BASE + 32'h0, 32'h0,         4'hF, 1'b1, 32'h1234_ABCD});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'h8, 32'h0,         4'hF, 1'b1, 32'h0001_0000});
    vecs.push_back('{1'b1, 1'b0, BASE + 32'h0, 32'hFFFF_FFFF, 4'b0010, 1'b1, 32'h1234_ABCD});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'h0, 32'h0,         4'hF, 1'b1, 32'h1234_FFCD});
    vecs.push_back('{1'b1, 1'b1, BASE + 32'h0, 32'h0,         4'b1000, 1'b1, 32'h1234_FFCD});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'h0, 32'h0,         4'hF, 1'b1, 32'h0034_FFCD});
    vecs.push_back('{1'b1, 1'b0, BASE + 32'hC, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'hC, 32'h0,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'h2, 32'h0,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, BASE + 32'h4, 32'hFFFF_FFFF, 4'b1110, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'h4, 32'h0,         4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, BASE + 32'h4, 32'h0000_0002, 4'b0001, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'h4, 32'h0,         4'hF, 1'b1, 32'h2});
    vecs.push_back('{1'b1, 1'b0, BASE + 32'h4, 32'h0,         4'b0001, 1'b1, 32'h2});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFE_0000, 32'h0,        4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h5555_5555, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'h0, 32'h0,         4'hF, 1'b1, 32'h0034_FFCD});

    reset = 1'b1;
    dbg_data = 32'h0;
    bus_idle();
    ma = model_reset();
    mb = model_reset();
    #2 reset = 1'b0;

    // Reset held with random traffic: all outputs stay 0
    for (int i = 0; i < 6; i++) begin
      bus_random();
      tick();
      chk("reset_outs_h16", {cs_a, odata_a, ready_a, rdata_a}, 66'h0);
      chk("reset_outs_h1",  {cs_b, odata_b, ready_b, rdata_b}, 66'h0);
    end
    bus_idle();
    dbg_data = 32'h0;
    reset = 1'b1;

    // Idle after release: no loads while the source equals 0
    ncs = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cs_a || cs_b) ncs++;
    end
    chk("idle_no_cs", 66'(ncs), 66'h0);

    // First write: ack after E0, load strobe after E1, single cycle
    bus_set(1'b1, 1'b0, BASE, 32'h1234_ABCD, 4'hF);
    tick();
    chk("first_wr_ready", 66'(ready_a), 66'h1);
    bus_idle();
    tick();
    chk("first_cs", 66'(cs_a), 66'h1);
    chk("first_odata", 66'(odata_a), 66'h1234_ABCD);
    tick();
    chk("first_cs_one_cycle", 66'(cs_a), 66'h0);

    // Register map vectors, applied back to back
    foreach (vecs[i]) begin
      bus_set(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      tick();
      chk($sformatf("vec%0d_ready", i), 66'(ready_a), 66'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_rdata", i), 66'(rdata_a), 66'(vecs[i].exp_rdata));
    end
    bus_idle();
    tick();
    chk("ready_drops", 66'({ready_a, rdata_a}), 66'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("byte_write_committed", 66'(odata_a), 66'h0034_FFCD);

    // Hold window: 0x11 now, 0x22 dropped, 0x33 exactly 16 cycles later
    bus_set(1'b1, 1'b0, BASE, 32'h11, 4'hF);
    tick();
    p1_k = -1; p2_k = -1; p1_d = '0; p2_d = '0; ncs = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3)      bus_set(1'b1, 1'b0, BASE, 32'h22, 4'hF);
      else if (k == 5) bus_set(1'b1, 1'b0, BASE, 32'h33, 4'hF);
      else if (k == 8) bus_set(1'b0, 1'b1, BASE + 32'h8, 32'h0, 4'hF);
      else             bus_idle();
      tick();
      if (k == 8) chk("status_wait_bit", 66'({ready_a, rdata_a[0]}), 66'h3);
      if (cs_a) begin
        ncs++;
        if (p1_k < 0)      begin p1_k = k; p1_d = odata_a; end
        else if (p2_k < 0) begin p2_k = k; p2_d = odata_a; end
      end
    end
    chk("hold_pulse_count", 66'(ncs), 66'h2);
    chk("hold_pulse1_time", 66'(p1_k), 66'd1);
    chk("hold_pulse1_data", 66'(p1_d), 66'h11);
    chk("hold_pulse2_time", 66'(p2_k), 66'd17);
    chk("hold_pulse2_data", 66'(p2_d), 66'h33);

    // Revert inside the window: no second load, count unchanged, back to IDLE
    bus_set(1'b1, 1'b0, BASE, 32'hAA, 4'hF);
    tick();
    bus_idle();
    tick();
    chk("revert_first_cs", 66'({cs_a, odata_a}), {34'h1, 32'hAA});
    ncs = 0;
    cnt1 = '0;
    for (int k = 2; k <= 40; k++) begin
      if (k == 2)       bus_set(1'b1, 1'b0, BASE, 32'hBB, 4'hF);
      else if (k == 4)  bus_set(1'b1, 1'b0, BASE, 32'hAA, 4'hF);
      else if (k == 3 || k == 30) bus_set(1'b0, 1'b1, BASE + 32'h8, 32'h0, 4'hF);
      else              bus_idle();
      tick();
      if (cs_a) ncs++;
      if (k == 3) cnt1 = rdata_a[31:16];
      if (k == 30) chk("revert_status", 66'(rdata_a), 66'({cnt1, 16'h0}));
    end
    chk("revert_no_pulse", 66'(ncs), 66'h0);

    // Freeze with debug source: no loads until FREEZE clears
    bus_set(1'b1, 1'b0, BASE + 32'h4, 32'h3, 4'b0001);
    tick();
    bus_idle();
    ncs = 0;
    for (int i = 0; i < 40; i++) begin
      dbg_data = dbg_data + 32'd1;
      tick();
      if (cs_a || cs_b) ncs++;
    end
    chk("freeze_no_cs", 66'(ncs), 66'h0);
    dbg_data = dbg_data + 32'd1;
    bus_set(1'b1, 1'b0, BASE + 32'h4, 32'h1, 4'b0001);
    tick();
    bus_idle();
    dbg_data = dbg_data + 32'd1;
    exp_dbg = dbg_data;
    tick();
    chk("unfreeze_cs", 66'({cs_a, odata_a}), {34'h1, exp_dbg});
    p1_k = -1; p2_k = -1; ncs = 0;
    begin
      int nb = 0;
      for (int t = 1; t <= 40; t++) begin
        dbg_data = dbg_data + 32'd1;
        tick();
        if (cs_b) nb++;
        if (cs_a) begin
          ncs++;
          if (p1_k < 0)      p1_k = t;
          else if (p2_k < 0) p2_k = t;
        end
      end
      chk("h1_every_cycle", 66'(nb), 66'd40);
    end
    chk("dbg_pulse_count", 66'(ncs), 66'h2);
    chk("dbg_pulse1_time", 66'(p1_k), 66'd16);
    chk("dbg_pulse2_time", 66'(p2_k), 66'd32);
    bus_set(1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'b0001);
    tick();

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      bus_random();
      if (reset && $urandom_range(0, 199) == 0) reset = 1'b0;
      else if (!reset && $urandom_range(0, 1) == 0) reset = 1'b1;
      tick();
    end
    reset = 1'b1;
    bus_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
